// File: rtl/mem_port_arbiter.sv
// Two-port (IF/DM) arbiter and MOV/MOC sequencer in front of ram256x8, with a MOC watchdog.
// Optional ROUND_ROBIN_EN: alternate grants on simultaneous requests; default is fixed DM-over-IF priority.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MOC_TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              IF_MOV,
  input  logic [ADDR_W-1:0] IF_Address,
  output logic              IF_MOC,
  output logic [DATA_W-1:0] IF_DataOut,
  input  logic              DM_MOV,
  input  logic              DM_ReadWrite,
  input  logic [2:0]        DM_MS_2_0,
  input  logic [DATA_W-1:0] DM_DataIn,
  input  logic [ADDR_W-1:0] DM_Address,
  output logic              DM_MOC,
  output logic [DATA_W-1:0] DM_DataOut,
  output logic              MOV,
  output logic              ReadWrite,
  output logic [2:0]        MS_2_0,
  output logic [DATA_W-1:0] DataIn,
  output logic [ADDR_W-1:0] Address,
  input  logic              MOC,
  input  logic [DATA_W-1:0] DataOut,
  output logic [1:0]        Grant,
  output logic              Timeout
);

  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE, ST_RELEASE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [2:0]        ms;
    logic [DATA_W-1:0] data;
  } cmd_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IF   = 2'b01;
  localparam logic [1:0] GNT_DM   = 2'b10;

  state_t            state_q, state_d;
  cmd_t              cmd_q, if_cmd, dm_cmd;
  logic [1:0]        grant_q;
  logic [7:0]        cnt_q;
  logic [8:0]        cnt_inc;
  logic              expire;
  logic              timeout_q;
  logic [DATA_W-1:0] if_dout_q, dm_dout_q;
  logic              any_req, pick_dm;

  always_comb begin
    if_cmd      = '0;
    if_cmd.addr = IF_Address;
    if_cmd.rw   = 1'b1;
    if_cmd.ms   = 3'b010;
    dm_cmd      = '0;
    dm_cmd.addr = DM_Address;
    dm_cmd.rw   = DM_ReadWrite;
    dm_cmd.ms   = DM_MS_2_0;
    dm_cmd.data = DM_DataIn;
  end

  assign any_req = IF_MOV | DM_MOV;

`ifdef ROUND_ROBIN_EN
  logic last_dm_q;
  // On a tie the port that did not win last time goes first.
  assign pick_dm = DM_MOV && (!IF_MOV || !last_dm_q);
`else
  assign pick_dm = DM_MOV;
`endif

  // Expiry is judged on the count this WAIT cycle completes; MOC in the same cycle still wins.
  assign cnt_inc = {1'b0, cnt_q} + 9'd1;
  assign expire  = (cnt_inc == 9'(MOC_TIMEOUT));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (any_req) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_WAIT;
      ST_WAIT:    if (MOC || expire) state_d = ST_DONE;
      ST_DONE:    state_d = ST_RELEASE;
      ST_RELEASE: if (!MOC) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= GNT_NONE;
      cmd_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      if_dout_q <= '0;
      dm_dout_q <= '0;
`ifdef ROUND_ROBIN_EN
      last_dm_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            grant_q <= pick_dm ? GNT_DM : GNT_IF;
            cmd_q   <= pick_dm ? dm_cmd : if_cmd;
`ifdef ROUND_ROBIN_EN
            last_dm_q <= pick_dm;
`endif
          end
        end
        ST_ISSUE: cnt_q <= '0;
        ST_WAIT: begin
          cnt_q <= cnt_inc[7:0];
          if (MOC) begin
            if (cmd_q.rw) begin
              if (grant_q == GNT_IF) if_dout_q <= DataOut;
              else                   dm_dout_q <= DataOut;
            end
          end else if (expire) begin
            timeout_q <= 1'b1;
            if (grant_q == GNT_IF) if_dout_q <= '0;
            else                   dm_dout_q <= '0;
          end
        end
        ST_RELEASE: begin
          if (!MOC) grant_q <= GNT_NONE;
        end
        default: ;
      endcase
    end
  end

  assign MOV        = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign IF_MOC     = (state_q == ST_DONE) && (grant_q == GNT_IF);
  assign DM_MOC     = (state_q == ST_DONE) && (grant_q == GNT_DM);
  assign ReadWrite  = cmd_q.rw;
  assign MS_2_0     = cmd_q.ms;
  assign DataIn     = cmd_q.data;
  assign Address    = cmd_q.addr;
  assign Grant      = grant_q;
  assign Timeout    = timeout_q;
  assign IF_DataOut = if_dout_q;
  assign DM_DataOut = dm_dout_q;

  a_grant_onehot: assert property (@(posedge CLK) disable iff (Reset) $onehot0(Grant));
  a_mov_granted:  assert property (@(posedge CLK) disable iff (Reset) MOV |-> (Grant != GNT_NONE));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: byte-array RAM model plus a shadow memory scoreboard.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        IF_MOV;
  logic [31:0] IF_Address;
  logic        IF_MOC;
  logic [31:0] IF_DataOut;
  logic        DM_MOV, DM_ReadWrite;
  logic [2:0]  DM_MS_2_0;
  logic [31:0] DM_DataIn, DM_Address;
  logic        DM_MOC;
  logic [31:0] DM_DataOut;
  logic        MOV, ReadWrite;
  logic [2:0]  MS_2_0;
  logic [31:0] DataIn, Address;
  logic        MOC = 1'b0;
  logic [31:0] DataOut = '0;
  logic [1:0]  Grant;
  logic        Timeout;

  mem_port_arbiter dut (
    .CLK(CLK), .Reset(Reset),
    .IF_MOV(IF_MOV), .IF_Address(IF_Address), .IF_MOC(IF_MOC), .IF_DataOut(IF_DataOut),
    .DM_MOV(DM_MOV), .DM_ReadWrite(DM_ReadWrite), .DM_MS_2_0(DM_MS_2_0), .DM_DataIn(DM_DataIn),
    .DM_Address(DM_Address), .DM_MOC(DM_MOC), .DM_DataOut(DM_DataOut),
    .MOV(MOV), .ReadWrite(ReadWrite), .MS_2_0(MS_2_0), .DataIn(DataIn), .Address(Address),
    .MOC(MOC), .DataOut(DataOut), .Grant(Grant), .Timeout(Timeout)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int exp_if = 0, exp_dm = 0;
  int if_done_cyc, dm_done_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- RAM model (big-endian byte array, MOV/MOC handshake) ----------------
  logic [7:0] ram [256];
  logic [7:0] ref_mem [256];
  bit         hang = 0, lag = 0;
  int         dly = 0;
  logic       pl_en = 0;
  logic [7:0] pl_addr = '0, pl_data = '0;

  function automatic logic [31:0] rd(input bit use_ref, input logic [7:0] a, input logic [2:0] ms);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = use_ref ? ref_mem[a + 8'(i)] : ram[a + 8'(i)];
    case (ms[1:0])
      2'b00:   return ms[2] ? {{24{b[0][7]}}, b[0]} : {24'h0, b[0]};
      2'b01:   return ms[2] ? {{16{b[0][7]}}, b[0], b[1]} : {16'h0, b[0], b[1]};
      default: return {b[0], b[1], b[2], b[3]};
    endcase
  endfunction

  task automatic ref_wr(input logic [7:0] a, input logic [2:0] ms, input logic [31:0] d);
    case (ms[1:0])
      2'b00: ref_mem[a] = d[7:0];
      2'b01: begin ref_mem[a] = d[15:8]; ref_mem[a + 8'd1] = d[7:0]; end
      default: for (int i = 0; i < 4; i++) ref_mem[a + 8'(i)] = d[31-8*i -: 8];
    endcase
  endtask

  always @(posedge CLK) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    if (!MOV) begin
      if (!(lag && MOC && $urandom_range(0, 2) != 0)) MOC <= 1'b0;
      dly <= lag ? int'($urandom_range(0, 3)) : 0;
    end else if (!MOC && !hang) begin
      if (dly == 0) begin
        MOC <= 1'b1;
        if (ReadWrite) DataOut <= rd(1'b0, Address[7:0], MS_2_0);
        else begin
          case (MS_2_0[1:0])
            2'b00: ram[Address[7:0]] <= DataIn[7:0];
            2'b01: begin ram[Address[7:0]] <= DataIn[15:8]; ram[Address[7:0] + 8'd1] <= DataIn[7:0]; end
            default: for (int i = 0; i < 4; i++) ram[Address[7:0] + 8'(i)] <= DataIn[31-8*i -: 8];
          endcase
        end
      end else dly <= dly - 1;
    end
  end

  // ---------------- monitor ----------------
  always @(posedge CLK) cyc <= cyc + 1;

  logic        mov_q = 0, ifm_q = 0, dmm_q = 0;
  logic [67:0] cmd_tb = '0;
  int          issue_cyc = 0, if_pulses = 0, dm_pulses = 0, stab_err = 0, wide_err = 0;
  logic [31:0] iss_addr = '0;
  logic [2:0]  iss_ms = '0;
  logic        iss_rw = 0;
  logic [1:0]  glog [$];

  always @(negedge CLK) begin
    mov_q  <= MOV;
    ifm_q  <= IF_MOC;
    dmm_q  <= DM_MOC;
    cmd_tb <= {Address, ReadWrite, MS_2_0, DataIn};
    if (MOV && !mov_q) begin
      issue_cyc <= cyc;
      iss_addr  <= Address;
      iss_ms    <= MS_2_0;
      iss_rw    <= ReadWrite;
      glog.push_back(Grant);
    end
    if (MOV && mov_q && ({Address, ReadWrite, MS_2_0, DataIn} != cmd_tb)) stab_err <= stab_err + 1;
    if (IF_MOC) if_pulses <= if_pulses + 1;
    if (DM_MOC) dm_pulses <= dm_pulses + 1;
    if ((IF_MOC && ifm_q) || (DM_MOC && dmm_q) || (IF_MOC && DM_MOC)) wide_err <= wide_err + 1;
  end

  // ---------------- port drivers ----------------
  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge CLK);
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic wait_if(output bit ok);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLK);
      if (IF_MOC) begin ok = 1; if_done_cyc = cyc; end
    end
  endtask

  task automatic wait_dm(output bit ok);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLK);
      if (DM_MOC) begin ok = 1; dm_done_cyc = cyc; end
    end
  endtask

  task automatic wait_mov(output bit ok);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge CLK);
      if (MOV) ok = 1;
    end
  endtask

  task automatic if_op(input logic [7:0] a, output logic [31:0] q, output bit ok);
    IF_Address = {24'h0, a};
    IF_MOV = 1'b1;
    wait_if(ok);
    q = IF_DataOut;
    IF_MOV = 1'b0;
    if (ok) exp_if++;
    @(negedge CLK);
  endtask

  task automatic dm_op(input logic rw, input logic [2:0] ms, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] q, output bit ok);
    DM_ReadWrite = rw; DM_MS_2_0 = ms; DM_Address = {24'h0, a}; DM_DataIn = d;
    DM_MOV = 1'b1;
    wait_dm(ok);
    q = DM_DataOut;
    DM_MOV = 1'b0;
    if (ok) exp_dm++;
    @(negedge CLK);
  endtask

  task automatic serve_both(input logic [7:0] ia, input logic [7:0] da);
    bit idone, ddone;
    idone = 0; ddone = 0;
    IF_Address = {24'h0, ia}; IF_MOV = 1'b1;
    DM_Address = {24'h0, da}; DM_ReadWrite = 1'b1; DM_MS_2_0 = 3'b010; DM_MOV = 1'b1;
    for (int i = 0; i < 300 && !(idone && ddone); i++) begin
      @(negedge CLK);
      if (IF_MOC) begin IF_MOV = 1'b0; idone = 1; exp_if++; chk("t3_if_data", IF_DataOut, rd(1'b1, ia, 3'b010)); end
      if (DM_MOC) begin DM_MOV = 1'b0; ddone = 1; exp_dm++; chk("t3_dm_data", DM_DataOut, rd(1'b1, da, 3'b010)); end
    end
    chk("t3_both_done", {30'h0, idone, ddone}, 32'd3);
    @(negedge CLK);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] q, pre;
    bit ok, ok2;
    int t0, d;
    logic [1:0] gexp [4];

    Reset = 1'b1; IF_MOV = 0; IF_Address = '0;
    DM_MOV = 0; DM_ReadWrite = 1'b1; DM_MS_2_0 = '0; DM_DataIn = '0; DM_Address = '0;
    @(negedge CLK);
    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
    poke(8'd4, 8'hE3); poke(8'd5, 8'hA0); poke(8'd6, 8'h10); poke(8'd7, 8'h05);

    chk("rst_mov", MOV, 0);
    chk("rst_grant", Grant, 0);
    chk("rst_if_moc", IF_MOC, 0);
    chk("rst_dm_moc", DM_MOC, 0);
    chk("rst_if_dout", IF_DataOut, 0);
    chk("rst_dm_dout", DM_DataOut, 0);
    chk("rst_timeout", Timeout, 0);
    Reset = 1'b0;

    // 1: IF word fetch at minimum latency
    t0 = cyc;
    IF_Address = 32'd4; IF_MOV = 1'b1;
    wait_if(ok);
    chk("t1_done", ok, 1);
    chk("t1_latency", if_done_cyc - t0, 3);
    chk("t1_data", IF_DataOut, 32'hE3A01005);
    chk("t1_ms", iss_ms, 3'b010);
    chk("t1_rw", iss_rw, 1);
    chk("t1_addr", iss_addr, 4);
    chk("t1_grant", Grant, 2'b01);
    IF_MOV = 1'b0; exp_if++;
    repeat (2) @(negedge CLK);
    chk("t1_grant_clr", Grant, 2'b00);
    chk("t1_pulses", if_pulses, 1);

    // 2: DM byte write then byte read
    pre = DM_DataOut;
    dm_op(1'b0, 3'b000, 8'd1, 32'h000000C3, q, ok);
    chk("t2_wr_done", ok, 1);
    chk("t2_wr_keep", DM_DataOut, pre);
    ref_wr(8'd1, 3'b000, 32'hC3);
    dm_op(1'b1, 3'b000, 8'd1, 32'h0, q, ok);
    chk("t2_rd_done", ok, 1);
    chk("t2_rd_data", q, 32'h000000C3);

    // 3: simultaneous requests, twice
    glog.delete();
    serve_both(8'd136, 8'd20);
    serve_both(8'd144, 8'd24);
`ifdef ROUND_ROBIN_EN
    gexp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    gexp = '{2'b10, 2'b01, 2'b10, 2'b01};
`endif
    chk("t3_nissues", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk($sformatf("t3_grant%0d", i), glog[i], gexp[i]);

    // 4: hung RAM -> watchdog abort
    hang = 1;
    dm_op(1'b1, 3'b010, 8'd8, 32'h0, q, ok);
    chk("t4_done", ok, 1);
    chk("t4_abort_cyc", dm_done_cyc - issue_cyc, 17);
    chk("t4_data_zero", q, 0);
    chk("t4_timeout", Timeout, 1);
    hang = 0;
    dm_op(1'b1, 3'b010, 8'd8, 32'h0, q, ok);
    chk("t4_after_done", ok, 1);
    chk("t4_after_data", q, rd(1'b1, 8'd8, 3'b010));
    chk("t4_sticky", Timeout, 1);

    // 5: reset during WAIT, held request reissued
    hang = 1;
    DM_ReadWrite = 1'b1; DM_MS_2_0 = 3'b010; DM_Address = 32'd12; DM_MOV = 1'b1;
    wait_mov(ok);
    chk("t5_issued", ok, 1);
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    chk("t5_mov", MOV, 0);
    chk("t5_grant", Grant, 0);
    chk("t5_timeout", Timeout, 0);
    chk("t5_dm_dout", DM_DataOut, 0);
    chk("t5_if_dout", IF_DataOut, 0);
    Reset = 1'b0; hang = 0;
    wait_dm(ok);
    q = DM_DataOut;
    DM_MOV = 1'b0;
    if (ok) exp_dm++;
    @(negedge CLK);
    chk("t5_reissue_done", ok, 1);
    chk("t5_reissue_data", q, rd(1'b1, 8'd12, 3'b010));

    // 6: IF arrives while DM in flight
    DM_ReadWrite = 1'b1; DM_MS_2_0 = 3'b010; DM_Address = 32'd16; DM_MOV = 1'b1;
    wait_mov(ok);
    IF_Address = 32'd140; IF_MOV = 1'b1;
    wait_dm(ok);
    q = DM_DataOut;
    DM_MOV = 1'b0;
    if (ok) exp_dm++;
    d = dm_done_cyc;
    wait_if(ok2);
    IF_MOV = 1'b0;
    if (ok2) exp_if++;
    @(negedge CLK);
    chk("t6_dm_done", ok, 1);
    chk("t6_if_done", ok2, 1);
    chk("t6_dm_data", q, rd(1'b1, 8'd16, 3'b010));
    chk("t6_if_data", IF_DataOut, rd(1'b1, 8'd140, 3'b010));
    chk("t6_if_issue_gap", issue_cyc - d, 3);
    chk("t6_dm_intact", DM_DataOut, q);
    chk("t6_dm_pulses", dm_pulses, exp_dm);

    // random traffic on both ports; IF reads only the upper half, DM owns the lower half
    lag = 1;
    fork
      begin : if_drv
        logic [7:0] ia;
        logic [31:0] iq;
        bit iok;
        for (int n = 0; n < 12; n++) begin
          ia = 8'(128 + 4 * $urandom_range(0, 31));
          if_op(ia, iq, iok);
          chk("rnd_if_done", iok, 1);
          chk("rnd_if_data", iq, rd(1'b1, ia, 3'b010));
          repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
      end
      begin : dm_drv
        logic [2:0] ms;
        logic [7:0] a;
        logic [31:0] dd, dq, dpre;
        bit dok;
        logic rw;
        for (int n = 0; n < 20; n++) begin
          case ($urandom_range(0, 4))
            0: ms = 3'b000;
            1: ms = 3'b001;
            2: ms = 3'b010;
            3: ms = 3'b100;
            default: ms = 3'b101;
          endcase
          a = 8'(4 * $urandom_range(0, 31));
          if (ms[1:0] == 2'b00) a = a + 8'($urandom_range(0, 3));
          else if (ms[1:0] == 2'b01) a = a + 8'(2 * $urandom_range(0, 1));
          rw = 1'($urandom_range(0, 1));
          dd = $urandom;
          dpre = DM_DataOut;
          dm_op(rw, ms, a, dd, dq, dok);
          chk("rnd_dm_done", dok, 1);
          if (rw) chk("rnd_dm_rd", dq, rd(1'b1, a, ms));
          else begin
            chk("rnd_dm_wr_keep", DM_DataOut, dpre);
            ref_wr(a, ms, dd);
          end
          repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
      end
    join
    repeat (4) @(negedge CLK);

    chk("end_if_pulses", if_pulses, exp_if);
    chk("end_dm_pulses", dm_pulses, exp_dm);
    chk("end_cmd_stable", stab_err, 0);
    chk("end_moc_width", wide_err, 0);
    chk("end_timeout", Timeout, 0);
    chk("end_grant_idle", Grant, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL sim_time_limit: got expired expected finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-port arbiter and sequencer placed in front of ram256x8. It shares the single MOV/MOC memory interface between the instruction-fetch port (IF) and the data-memory port (DM) of the ARM datapath. It latches the granted command, drives the RAM handshake and returns read data plus a per-port completion pulse. A MOC watchdog flags a hung memory.

Parameters:
ADDR_W, 32, address width on all ports
DATA_W, 32, data width on all ports
MOC_TIMEOUT, 16, WAIT-state cycles without MOC before abort (1..255)

Ports:
CLK  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
IF_MOV  in  1  fetch request; held high until IF_MOC pulse
IF_Address  in  ADDR_W  fetch address; always a word read (MS 010, ReadWrite 1)
IF_MOC  out  1  one-cycle completion pulse to fetch port
IF_DataOut  out  DATA_W  registered fetch data
DM_MOV  in  1  data request; held high until DM_MOC pulse
DM_ReadWrite  in  1  1 = read, 0 = write
DM_MS_2_0  in  3  size/sign code passed unchanged to RAM
DM_DataIn  in  DATA_W  write data
DM_Address  in  ADDR_W  data address
DM_MOC  out  1  one-cycle completion pulse to data port
DM_DataOut  out  DATA_W  registered read data
MOV  out  1  RAM operation request
ReadWrite  out  1  to RAM
MS_2_0  out  3  to RAM
DataIn  out  DATA_W  to RAM
Address  out  ADDR_W  to RAM
MOC  in  1  RAM operation complete
DataOut  in  DATA_W  RAM read bus
Grant  out  2  debug: 01 = IF, 10 = DM, 00 = none
Timeout  out  1  sticky watchdog error

Behaviour:
- One clock (CLK), synchronous active-high Reset.
- Reset values: state IDLE; MOV, IF_MOC, DM_MOC, Timeout = 0; Grant = 00; IF_DataOut, DM_DataOut = 0; latched command = 0; last-grant = DM.
- FSM states: IDLE, ISSUE, WAIT, DONE, RELEASE.
- IDLE: if any request is pending, pick a winner, latch its Address/ReadWrite/MS_2_0/DataIn, set Grant, go to ISSUE. Otherwise stay.
- ISSUE: MOV = 1, watchdog counter = 0, go to WAIT.
- WAIT: MOV = 1, counter increments each cycle.
  - MOC = 1: if read, capture DataOut into the granted port's DataOut register; go to DONE.
  - Counter = MOC_TIMEOUT with MOC still 0: Timeout <= 1, granted port's DataOut <= 0, go to DONE.
  - A MOC arriving in the same cycle as expiry counts as success.
- DONE: MOV = 0, granted port's MOC = 1 for exactly this cycle, go to RELEASE.
- RELEASE: MOV = 0. Wait until RAM MOC = 0, then Grant <= 00 and go to IDLE. Requesters must drop their MOV by this cycle, so IDLE never re-grants a finished request.
- MOV, ReadWrite, MS_2_0, DataIn and Address are stable from ISSUE through RELEASE. In IDLE they hold their last values with MOV = 0.
- Writes leave the requester's DataOut unchanged. IF_DataOut changes only on IF completions; DM_DataOut changes only on DM completions.
- A request arriving while the other port is in flight waits in IDLE arbitration; it is never dropped.
- Minimum latency: request sampled in IDLE at cycle 0 -> ISSUE at 1 -> WAIT at 2 (MOC seen) -> MOC pulse at 3.
- Timeout clears only on Reset.
- Reset mid-transaction: next cycle is IDLE with MOV = 0 and all outputs at reset values. A still-held request is re-arbitrated from scratch.

Optional Feature:
ROUND_ROBIN_EN
- Defined: on simultaneous requests, grant the port not granted last. The last-grant register updates on every grant; reset value DM, so IF wins the first tie.
- Undefined: fixed priority, DM always beats IF; the last-grant register is not implemented.

Test Plan:
1. Reset; preload word 0xE3A01005 at address 4; IF_MOV = 1, IF_Address = 4 -> RAM sees MS_2_0 = 010, ReadWrite = 1; single IF_MOC pulse; IF_DataOut = 0xE3A01005; Grant 01 -> 00.
2. DM write byte 0xC3 to address 1 (MS 000, RW 0), then DM read byte at address 1 -> DM_DataOut = 0x000000C3; DM_DataOut unchanged after the write.
3. IF and DM request in the same cycle, twice -> without macro: DM, IF, DM, IF; with ROUND_ROBIN_EN: IF, DM, IF, DM (Grant sequence checked).
4. RAM model holds MOC = 0; DM read -> DM_MOC pulses 17 cycles after ISSUE, DM_DataOut = 0, Timeout = 1 and stays 1 until Reset.
5. Reset asserted during WAIT -> next edge MOV = 0, Grant = 00, Timeout = 0. Held DM request reissued and completes normally.
6. IF_MOV rises during a DM transaction -> IF serviced immediately after DM's RELEASE; no extra DM_MOC; DM_DataOut intact.
